// File: rtl/mem_wb_stage.sv
// X/M and M/W pipeline registers with a req/ack data-memory port.
// Stalls upstream while an access waits; aborts after TIMEOUT stall cycles.
module mem_wb_stage #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_out_x,
  input  logic [15:0] store_data_x,
  input  logic [3:0]  rd_x,
  input  logic        reg_write_x,
  input  logic        mem_read_x,
  input  logic        mem_write_x,
  input  logic        b_m2m,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_stall,
  output logic [15:0] alu_out_xm,
  output logic [3:0]  rd_xm,
  output logic        reg_write_xm,
  output logic        mem_write_xm,
  output logic [15:0] writeback_data,
  output logic [3:0]  rd_mw,
  output logic        reg_write_mw,
  output logic        mem_error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [15:0] r_alu_xm;
  logic [15:0] r_sd_xm;
  logic [3:0]  r_rd_xm;
  logic        r_rw_xm;
  logic        r_mr_xm;
  logic        r_mw_xm;

  logic [15:0] r_alu_mw;
  logic [15:0] r_ld_mw;
  logic [3:0]  r_rd_mw;
  logic        r_rw_mw;
  logic        r_m2r_mw;

  logic             w_mem_op;
  logic             w_idle;
  logic             w_busy;
  logic             w_abort;
  logic             w_stall;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  logic [15:0]      w_wb;

  assign w_mem_op  = r_mr_xm | r_mw_xm;
  assign w_idle    = (r_state == S_IDLE);
  assign w_busy    = (r_state == S_BUSY);
  assign w_abort   = (r_state == S_ABORT);
  // r_cnt holds stall cycles already spent; w_last marks the final one
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_last    = (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_stall   = (w_idle & w_mem_op & ~mem_ack) | (w_busy & ~mem_ack);
  assign w_wb      = r_m2r_mw ? r_ld_mw : r_alu_mw;

  assign mem_stall      = w_stall;
  assign mem_req        = (w_idle & w_mem_op) | w_busy;
  assign mem_we         = r_mw_xm;
  assign mem_addr       = r_alu_xm;
  assign mem_wdata      = b_m2m ? w_wb : r_sd_xm;
  assign alu_out_xm     = r_alu_xm;
  assign rd_xm          = r_rd_xm;
  assign reg_write_xm   = r_rw_xm;
  assign mem_write_xm   = r_mw_xm;
  assign writeback_data = w_wb;
  assign rd_mw          = r_rd_mw;
  assign reg_write_mw   = r_rw_mw;
  assign mem_error      = r_err;

  // Access FSM: wait counting, timeout abort, sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mem_op & ~mem_ack) begin
            r_cnt   <= w_cnt_inc;
            r_state <= w_last ? S_ABORT : S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= w_cnt_inc;
            if (w_last)
              r_state <= S_ABORT;
          end
        end
        S_ABORT: begin
          r_err   <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // X/M register: advances whenever the memory stage is not stalling
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_xm <= '0;
      r_sd_xm  <= '0;
      r_rd_xm  <= '0;
      r_rw_xm  <= 1'b0;
      r_mr_xm  <= 1'b0;
      r_mw_xm  <= 1'b0;
    end else if (!w_stall) begin
      r_alu_xm <= alu_out_x;
      r_sd_xm  <= store_data_x;
      r_rd_xm  <= rd_x;
      r_rw_xm  <= reg_write_x;
      r_mr_xm  <= mem_read_x;
      r_mw_xm  <= mem_write_x;
    end
  end

  // M/W register: aborted accesses enter as a bubble; read+write acts as store
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_mw <= '0;
      r_ld_mw  <= '0;
      r_rd_mw  <= '0;
      r_rw_mw  <= 1'b0;
      r_m2r_mw <= 1'b0;
    end else if (!w_stall) begin
      r_alu_mw <= r_alu_xm;
      r_ld_mw  <= mem_rdata;
      r_rd_mw  <= r_rd_xm;
      r_rw_mw  <= r_rw_xm & ~w_abort;
      r_m2r_mw <= r_mr_xm & ~r_mw_xm & ~w_abort;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a per-cycle reference model.
// Model tracks stall cycles per access instead of an FSM state.
module tb_mem_wb_stage;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_out_x = '0;
  logic [15:0] store_data_x = '0;
  logic [3:0]  rd_x = '0;
  logic        reg_write_x = 1'b0;
  logic        mem_read_x = 1'b0;
  logic        mem_write_x = 1'b0;
  logic        b_m2m = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_req, mem_we, mem_stall;
  logic [15:0] mem_addr, mem_wdata, alu_out_xm, writeback_data;
  logic [3:0]  rd_xm, rd_mw;
  logic        reg_write_xm, mem_write_xm, reg_write_mw, mem_error;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .alu_out_x(alu_out_x), .store_data_x(store_data_x),
    .rd_x(rd_x), .reg_write_x(reg_write_x),
    .mem_read_x(mem_read_x), .mem_write_x(mem_write_x),
    .b_m2m(b_m2m), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_stall(mem_stall),
    .alu_out_xm(alu_out_xm), .rd_xm(rd_xm),
    .reg_write_xm(reg_write_xm), .mem_write_xm(mem_write_xm),
    .writeback_data(writeback_data), .rd_mw(rd_mw),
    .reg_write_mw(reg_write_mw), .mem_error(mem_error)
  );

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] sd;
    logic [3:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } op_t;

  op_t         m_xm;
  logic [15:0] m_alu_mw, m_ld_mw;
  logic [3:0]  m_rd_mw;
  logic        m_rw_mw, m_m2r_mw, m_err;
  int          m_wait;
  bit          armed = 1'b0;

  logic        e_op, e_abort, e_req, e_stall;
  logic [15:0] e_wb, e_wdata;

  // An access has used its budget once it has stalled TO cycles
  always_comb begin
    e_op    = m_xm.mr | m_xm.mw;
    e_abort = e_op && (m_wait == TO);
    e_req   = e_op && !e_abort;
    e_stall = e_req && !mem_ack;
    e_wb    = m_m2r_mw ? m_ld_mw : m_alu_mw;
    e_wdata = b_m2m ? e_wb : m_xm.sd;
  end

  // Reference pipeline advance
  always @(posedge clk) begin
    if (rst) begin
      armed    <= 1'b1;
      m_xm     <= '0;
      m_alu_mw <= '0;
      m_ld_mw  <= '0;
      m_rd_mw  <= '0;
      m_rw_mw  <= 1'b0;
      m_m2r_mw <= 1'b0;
      m_err    <= 1'b0;
      m_wait   <= 0;
    end else if (e_stall) begin
      m_wait <= m_wait + 1;
    end else begin
      m_wait   <= 0;
      m_xm     <= {alu_out_x, store_data_x, rd_x,
                   reg_write_x, mem_read_x, mem_write_x};
      m_alu_mw <= m_xm.alu;
      m_ld_mw  <= mem_rdata;
      m_rd_mw  <= m_xm.rd;
      m_rw_mw  <= m_xm.rw && !e_abort;
      m_m2r_mw <= m_xm.mr && !m_xm.mw && !e_abort;
      if (e_abort)
        m_err <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] alu, input logic [15:0] sd,
                        input logic [3:0] rd, input logic rw,
                        input logic mr, input logic mw);
    alu_out_x    = alu;
    store_data_x = sd;
    rd_x         = rd;
    reg_write_x  = rw;
    mem_read_x   = mr;
    mem_write_x  = mw;
  endtask

  task automatic nop;
    set_in(16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  int nstall;

  initial begin
    // Model compare on every falling edge once reset has been seen
    fork
      forever begin
        @(negedge clk);
        if (armed) begin
          chk("m_req", 16'(mem_req), 16'(e_req));
          chk("m_stall", 16'(mem_stall), 16'(e_stall));
          chk("m_we", 16'(mem_we), 16'(m_xm.mw));
          chk("m_addr", mem_addr, m_xm.alu);
          chk("m_wdata", mem_wdata, e_wdata);
          chk("m_alu_xm", alu_out_xm, m_xm.alu);
          chk("m_rd_xm", 16'(rd_xm), 16'(m_xm.rd));
          chk("m_rw_xm", 16'(reg_write_xm), 16'(m_xm.rw));
          chk("m_mw_xm", 16'(mem_write_xm), 16'(m_xm.mw));
          chk("m_wb", writeback_data, e_wb);
          chk("m_rd_mw", 16'(rd_mw), 16'(m_rd_mw));
          chk("m_rw_mw", 16'(reg_write_mw), 16'(m_rw_mw));
          chk("m_err", 16'(mem_error), 16'(m_err));
        end
      end
    join_none

    tick;
    tick;
    rst = 1'b0;
    chk("rst_wb", writeback_data, 16'h0000);
    chk("rst_req", 16'(mem_req), 16'h0);
    chk("rst_err", 16'(mem_error), 16'h0);

    // 1: plain ALU op, 1 and 2 cycle latency
    set_in(16'h1234, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0);
    tick;
    nop;
    chk("t1_alu_xm", alu_out_xm, 16'h1234);
    tick;
    chk("t1_wb", writeback_data, 16'h1234);
    chk("t1_rd_mw", 16'(rd_mw), 16'h3);
    chk("t1_rw_mw", 16'(reg_write_mw), 16'h1);

    // 2: zero-wait load
    set_in(16'h0040, 16'h0, 4'd5, 1'b1, 1'b1, 1'b0);
    tick;
    nop;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    chk("t2_stall", 16'(mem_stall), 16'h0);
    chk("t2_req", 16'(mem_req), 16'h1);
    chk("t2_addr", mem_addr, 16'h0040);
    chk("t2_we", 16'(mem_we), 16'h0);
    tick;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    chk("t2_wb", writeback_data, 16'hBEEF);
    chk("t2_rd_mw", 16'(rd_mw), 16'h5);

    // 3: store with M->M forward, acked after 3 wait cycles
    set_in(16'h00AA, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick;
    set_in(16'h0080, 16'h5555, 4'd0, 1'b0, 1'b0, 1'b1);
    tick;
    nop;
    b_m2m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall", 16'(mem_stall), 16'h1);
      chk("t3_req", 16'(mem_req), 16'h1);
      chk("t3_we", 16'(mem_we), 16'h1);
      chk("t3_wdata", mem_wdata, 16'h00AA);
      tick;
    end
    mem_ack = 1'b1;
    #1;
    chk("t3_rel", 16'(mem_stall), 16'h0);
    chk("t3_wdata_ack", mem_wdata, 16'h00AA);
    tick;
    mem_ack = 1'b0;
    b_m2m   = 1'b0;
    chk("t3_wb", writeback_data, 16'h0080);
    chk("t3_rw_mw", 16'(reg_write_mw), 16'h0);

    // 4: load never acked -> timeout abort
    set_in(16'h0100, 16'h0, 4'd7, 1'b1, 1'b1, 1'b0);
    tick;
    set_in(16'h7777, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0);
    nstall = 0;
    for (int i = 0; i <= TO; i++) begin
      #1;
      if (mem_stall)
        nstall++;
      if (i == TO)
        chk("t4_abort_req", 16'(mem_req), 16'h0);
      tick;
    end
    chk("t4_stalls", 16'(nstall), 16'(TO));
    chk("t4_err", 16'(mem_error), 16'h1);
    chk("t4_bubble", 16'(reg_write_mw), 16'h0);
    chk("t4_next", alu_out_xm, 16'h7777);
    nop;
    tick;
    chk("t4_wb", writeback_data, 16'h7777);
    chk("t4_rw_mw", 16'(reg_write_mw), 16'h1);
    chk("t4_sticky", 16'(mem_error), 16'h1);

    // 5: reset while BUSY, with ack in the same cycle
    set_in(16'h0200, 16'h0, 4'd4, 1'b1, 1'b1, 1'b0);
    tick;
    nop;
    tick;
    tick;
    chk("t5_busy", 16'(mem_stall), 16'h1);
    rst     = 1'b1;
    mem_ack = 1'b1;
    tick;
    chk("t5_req", 16'(mem_req), 16'h0);
    chk("t5_stall", 16'(mem_stall), 16'h0);
    chk("t5_alu_xm", alu_out_xm, 16'h0000);
    chk("t5_addr", mem_addr, 16'h0000);
    chk("t5_wdata", mem_wdata, 16'h0000);
    chk("t5_wb", writeback_data, 16'h0000);
    chk("t5_rd_mw", 16'(rd_mw), 16'h0);
    chk("t5_rw_mw", 16'(reg_write_mw), 16'h0);
    chk("t5_err", 16'(mem_error), 16'h0);
    rst     = 1'b0;
    mem_ack = 1'b0;
    tick;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
